// File: rtl/video_timing_pkg.sv
// Shared video timing definitions for the output-side video blocks.
// Holds the 720p default raster, total derivation, the counter width and
// the lock FSM state encoding used by axis_to_video_out.
package video_timing_pkg;

    // 1280x720 defaults
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    // Raster counter width; instantiating blocks check it against their totals.
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        ST_SEARCH     = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_LOCKED     = 2'd2
    } lock_state_e;

    function automatic int total_of(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset (counters -> 0,0)
//   hcnt_o, vcnt_o     : current pixel / line position
//   active_o           : position lies inside the active picture
//   hsync_o, vsync_o   : inside the sync interval (active-high, polarity applied by user)
//   frame_last_o       : last pixel of the last line of the frame
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_last_o
);
    localparam int H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ($clog2(H_TOTAL) > CNT_W || $clog2(V_TOTAL) > CNT_W) begin : g_width_check
        $error("video_timing_gen: CNT_W too small for raster totals");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             h_wrap;

    assign h_wrap = (hcnt_q == H_LAST);

    always_comb begin
        hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o       = hcnt_q;
    assign vcnt_o       = vcnt_q;
    assign active_o     = (hcnt_q < CNT_W'(H_ACTIVE)) && (vcnt_q < CNT_W'(V_ACTIVE));
    assign hsync_o      = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    assign vsync_o      = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    assign frame_last_o = h_wrap && (vcnt_q == V_LAST);

endmodule

// File: rtl/axis_to_video_out.sv
// AXI4-Stream video (tuser = SOF, tlast = EOL) to parallel video-out bus.
// The raster free-runs; the stream is locked to it at a frame boundary.
// Ports:
//   s_axis_video_aclk, rst : pixel clock, synchronous active-high reset
//   VIDEO_IN_*             : 24-bit AXIS video input, tready combinational
//   vid_data/de/hsync/vsync: registered video out, one cycle behind raster
//   locked                 : stream aligned to raster
//   underflow, misalign    : one-cycle error pulses (registered)
module axis_to_video_out
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        s_axis_video_aclk,
    input  logic        rst,
    input  logic [23:0] VIDEO_IN_tdata,
    input  logic        VIDEO_IN_tvalid,
    output logic        VIDEO_IN_tready,
    input  logic        VIDEO_IN_tuser,
    input  logic        VIDEO_IN_tlast,
    output logic [23:0] vid_data,
    output logic        vid_de,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        locked,
    output logic        underflow,
    output logic        misalign
);
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             active, hsync_raw, vsync_raw, frame_last;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i        (s_axis_video_aclk),
        .rst_i        (rst),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .active_o     (active),
        .hsync_o      (hsync_raw),
        .vsync_o      (vsync_raw),
        .frame_last_o (frame_last)
    );

    lock_state_e state_q, state_d;
    logic [23:0] data_q, data_d;
    logic        de_q, hs_q, vs_q;
    logic        und_q, und_d, mis_q, mis_d;
    logic        at_sof, at_eol;

    // Where the tuser/tlast flags must fall for the beat accepted now.
    assign at_sof = (hcnt == '0) && (vcnt == '0);
    assign at_eol = (hcnt == CNT_W'(H_ACTIVE - 1));

    always_comb begin
        state_d         = state_q;
        VIDEO_IN_tready = 1'b0;
        data_d          = '0;
        und_d           = 1'b0;
        mis_d           = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_SEARCH: begin
                    // Drain everything up to an SOF beat, then hold that beat.
                    VIDEO_IN_tready = !(VIDEO_IN_tvalid && VIDEO_IN_tuser);
                    if (VIDEO_IN_tvalid && VIDEO_IN_tuser) state_d = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (frame_last) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    VIDEO_IN_tready = active;
                    if (active) begin
                        if (!VIDEO_IN_tvalid) begin
                            und_d   = 1'b1;
                            state_d = ST_SEARCH;
                        end else begin
                            data_d = VIDEO_IN_tdata;
                            if ((VIDEO_IN_tuser != at_sof) || (VIDEO_IN_tlast != at_eol)) begin
                                mis_d   = 1'b1;
                                state_d = ST_SEARCH;
                            end
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            state_q <= ST_SEARCH;
            data_q  <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            und_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            de_q    <= active;
            hs_q    <= hsync_raw ? HSYNC_POL : ~HSYNC_POL;
            vs_q    <= vsync_raw ? VSYNC_POL : ~VSYNC_POL;
            und_q   <= und_d;
            mis_q   <= mis_d;
        end
    end

    assign vid_data  = data_q;
    assign vid_de    = de_q;
    assign vid_hsync = hs_q;
    assign vid_vsync = vs_q;
    assign locked    = (state_q == ST_LOCKED);
    assign underflow = und_q;
    assign misalign  = mis_q;

endmodule

// File: doc/axis_to_video_out.md
# axis_to_video_out

Converts an AXI4-Stream video stream (24-bit pixels, tuser = start of frame, tlast = end of line) into a parallel video-out bus: pixel data, data-enable, hsync and vsync, driven by an internal free-running timing generator. It is the transmit-side counterpart of the HDMI-input-to-AXIS path and sits between the processing chain and the HDMI/VGA output encoder. It locks the stream to the raster at a frame boundary and reports underflow and misalignment.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, hsync active level
- VSYNC_POL, 1, vsync active level
- s_axis_video_aclk  in  1  pixel clock, sole clock
- rst  in  1  synchronous, active-high reset
- VIDEO_IN_tdata  in  24  pixel
- VIDEO_IN_tvalid  in  1  beat valid
- VIDEO_IN_tready  out  1  beat accepted when tvalid & tready
- VIDEO_IN_tuser  in  1  start of frame (first pixel)
- VIDEO_IN_tlast  in  1  last pixel of line
- vid_data  out  24  output pixel, 0 outside active or when unlocked
- vid_de  out  1  data enable
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- locked  out  1  stream aligned to raster
- underflow  out  1  one-cycle pulse: active pixel with no valid beat
- misalign  out  1  one-cycle pulse: tuser/tlast at wrong raster position

## Operation
- Timing: hcnt 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP); vcnt increments when hcnt wraps, 0..V_TOTAL-1. Both counters free-run from reset and never stall on the stream.
- active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC; vsync asserted for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC. Both are line/pixel aligned; vsync is not offset within the line.
- Lock FSM, reset state SEARCH:
  - SEARCH: tready = !(tvalid & tuser). Non-SOF beats are discarded. When an SOF beat is presented, it is held and the FSM goes to WAIT_FRAME.
  - WAIT_FRAME: tready = 0. At hcnt=H_TOTAL-1 && vcnt=V_TOTAL-1 the FSM goes to LOCKED.
  - LOCKED: tready = active; locked = 1.
    - Active cycle with tvalid=0: underflow pulse; the pixel outputs 0 with de=1; go to SEARCH.
    - Accepted beat with tuser≠(hcnt==0 && vcnt==0), or tlast≠(hcnt==H_ACTIVE-1): misalign pulse; the beat is still output; go to SEARCH.
    - Underflow and misalign in the same cycle cannot occur, because misalign requires an accepted beat.
- de and syncs always follow the timing generator, independent of lock state; vid_data is 0 unless the beat was accepted in LOCKED.
- Reset mid-frame: counters go to (0,0), the FSM goes to SEARCH, and every output takes its reset value. The upstream beat held at reset is not consumed.

## Timing
- Reset values: vid_data=0, vid_de=0, vid_hsync=~HSYNC_POL, vid_vsync=~VSYNC_POL, locked=0, underflow=0, misalign=0, tready=0 while rst=1.
- All video outputs are registered with 1-cycle latency: the raster position and beat accepted in cycle N appear on the outputs in cycle N+1.
- tready is combinational from the FSM state, the counters and tvalid/tuser. There is no combinational path from tdata.
- locked rises the cycle after the WAIT_FRAME→LOCKED transition, which is the same cycle the first pixel is presented at (0,0). It falls the cycle after an error.
- Lock latency is at most 1 frame plus the time until the SOF beat arrives.

## Structure
- Package video_timing_pkg:
  - 720p default constants.
  - H_TOTAL/V_TOTAL derivation.
  - Counter width (12 bits, checked ≥ clog2 of totals).
  - FSM state encoding (SEARCH, WAIT_FRAME, LOCKED).
- Sub-module video_timing_gen: counters, active/hsync/vsync generation, and the last-pixel-of-frame flag. It is reusable by other output blocks.
- The top level holds the lock FSM, the output register stage and the error pulses.

## Test plan
All scenarios use small parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), 98 cycles per frame.
- Reset and free run, no stream: vid_de high for 8 of 14 cycles on lines 0–3; hsync on hcnt 10–11; vsync on line 5; vid_data=0; locked=0.
- Continuous 8×4 frames, always valid, pixel = {vcnt,hcnt}:
  - locked=1 from the first (0,0) after SOF.
  - Each output pixel equals its raster position, one cycle late.
  - tready is low outside active.
- Stream starts mid-frame with 5 junk beats and then SOF: the junk beats are consumed while in SEARCH; the SOF beat is held through WAIT_FRAME and output at the next (0,0).
- tvalid dropped for 1 cycle at (3,1) while locked:
  - underflow pulses once.
  - That pixel is 0 with de=1.
  - locked falls, then relocks at the next SOF.
- tlast on pixel 6 instead of 7: misalign pulses, locked falls, then resync.
- rst asserted mid-line while locked: every output equals its reset value next cycle; counters restart at (0,0); FSM in SEARCH.
